// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master N-slave decoder/mux with wait states, timeout and sticky bus error
module soc_bus_fabric #(
  parameter int                     N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE       = {32'h30000000, 32'h20000000, 32'h10000000, 32'h00000000},
  parameter logic [N_SLAVES*32-1:0] SLV_MASK       = {4{32'hF0000000}},
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [31:0]            ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wmask,
  input  logic                     mem_rstrb,
  output logic [31:0]              mem_rdata,
  output logic                     mem_rbusy,
  output logic                     mem_wbusy,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic [N_SLAVES-1:0]      s_ren,
  output logic [N_SLAVES-1:0]      s_wen,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_rvalid,
  input  logic [N_SLAVES-1:0]      s_wready,
  input  logic                     err_clr,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic                     err_is_wr
);
  localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  localparam int CW = 16;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR_RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] hidx, idx;
  logic          hit, is_wr, wreq, req, tmo;
  logic [31:0]   addr;
  logic [CW-1:0] cnt;
  assign wreq = |mem_wmask;
  assign req  = state == IDLE && (wreq || mem_rstrb);
  assign tmo  = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES);
  assign mem_rbusy = state == RD_WAIT || (state == ERR_RESP && !is_wr);
  assign mem_wbusy = state == WR_WAIT || (state == ERR_RESP && is_wr);
  // address decode, scanning downward so the lowest matching slave wins
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((mem_addr & SLV_MASK[i*32+:32]) == SLV_BASE[i*32+:32]) begin
        hit  = 1'b1;
        hidx = IW'(i);
      end
  end
  // state register
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : nxt;
  // next state: a response beats a coincident timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = wreq ? (hit ? WR_WAIT : ERR_RESP) : mem_rstrb ? (hit ? RD_WAIT : ERR_RESP) : IDLE;
      RD_WAIT:  nxt = s_rvalid[idx] ? IDLE : tmo ? ERR_RESP : RD_WAIT;
      WR_WAIT:  nxt = s_wready[idx] ? IDLE : tmo ? ERR_RESP : WR_WAIT;
      default:  nxt = IDLE;
    endcase
  end
  // request latch, one-cycle strobes, wait counter, read data and error capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0; addr <= '0; is_wr <= 1'b0; cnt <= '0;
      s_addr <= '0; s_wdata <= '0; s_wstrb <= '0; s_ren <= '0; s_wen <= '0;
      mem_rdata <= '0; bus_err <= 1'b0; err_addr <= '0; err_is_wr <= 1'b0;
    end else begin
      s_ren   <= '0;
      s_wen   <= '0;
      cnt     <= cnt + 1'b1;
      bus_err <= bus_err && !err_clr;
      if (req) begin
        idx     <= hidx;
        addr    <= mem_addr;
        is_wr   <= wreq;
        cnt     <= '0;
        s_addr  <= mem_addr & ~SLV_MASK[hidx*32+:32];
        s_wdata <= mem_wdata;
        s_wstrb <= mem_wmask;
        s_ren   <= hit && !wreq ? N_SLAVES'(1) << hidx : '0;
        s_wen   <= hit && wreq ? N_SLAVES'(1) << hidx : '0;
      end
      if (state == RD_WAIT && s_rvalid[idx])
        mem_rdata <= s_rdata[idx*32+:32];
      if (state == ERR_RESP) begin
        bus_err   <= 1'b1;
        err_addr  <= addr;
        err_is_wr <= is_wr;
        if (!is_wr)
          mem_rdata <= ERR_DATA;
      end
    end
  end
endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: directed checks of decode, wait states, timeout, errors and reset
module tb_soc_bus_fabric;
  logic         clk = 0;
  logic         reset_n = 0;
  logic [31:0]  mem_addr = 0, mem_wdata = 0;
  logic [3:0]   mem_wmask = 0;
  logic         mem_rstrb = 0;
  logic [31:0]  mem_rdata, s_addr, s_wdata, err_addr;
  logic         mem_rbusy, mem_wbusy, bus_err, err_is_wr;
  logic [3:0]   s_wstrb, s_ren, s_wen;
  logic [127:0] s_rdata = 0;
  logic [3:0]   s_rvalid = 0, s_wready = 0;
  logic         err_clr = 0;
  int checks = 0, errors = 0;

  soc_bus_fabric #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ren(s_ren), .s_wen(s_wen), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .s_wready(s_wready), .err_clr(err_clr), .bus_err(bus_err),
    .err_addr(err_addr), .err_is_wr(err_is_wr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_rbusy", 32'(mem_rbusy), 0);
    chk("rst_wbusy", 32'(mem_wbusy), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_s_ren", 32'(s_ren), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_err_addr", err_addr, 0);
    reset_n = 1;
    tick();
    // read slave 2, rvalid at T+1
    mem_addr = 32'h20000010; mem_rstrb = 1;
    s_rdata[31:0] = 32'h11111111; s_rdata[95:64] = 32'h12345678;
    tick();
    mem_rstrb = 0;
    chk("rd_s_ren", 32'(s_ren), 32'b0100);
    chk("rd_s_addr", s_addr, 32'h10);
    chk("rd_rbusy_t1", 32'(mem_rbusy), 1);
    s_rvalid = 4'b0100;
    tick();
    s_rvalid = 0;
    chk("rd_data", mem_rdata, 32'h12345678);
    chk("rd_rbusy_t2", 32'(mem_rbusy), 0);
    chk("rd_s_ren_off", 32'(s_ren), 0);
    // write slave 1, wready 3 cycles late
    mem_addr = 32'h10000004; mem_wdata = 32'hAA; mem_wmask = 4'b0001;
    tick();
    mem_wmask = 0;
    chk("wr_s_wen", 32'(s_wen), 32'b0010);
    chk("wr_s_wstrb", 32'(s_wstrb), 32'b0001);
    chk("wr_s_wdata", s_wdata, 32'hAA);
    chk("wr_s_addr", s_addr, 32'h4);
    chk("wr_wbusy_t1", 32'(mem_wbusy), 1);
    tick();
    chk("wr_s_wen_off", 32'(s_wen), 0);
    tick(); tick();
    chk("wr_wbusy_t4", 32'(mem_wbusy), 1);
    s_wready = 4'b0010;
    tick();
    s_wready = 0;
    chk("wr_wbusy_done", 32'(mem_wbusy), 0);
    chk("wr_no_err", 32'(bus_err), 0);
    // unmapped read
    mem_addr = 32'h50000000; mem_rstrb = 1;
    tick();
    mem_rstrb = 0;
    chk("um_no_ren", 32'(s_ren), 0);
    chk("um_rbusy_err", 32'(mem_rbusy), 1);
    tick();
    chk("um_bus_err", 32'(bus_err), 1);
    chk("um_err_addr", err_addr, 32'h50000000);
    chk("um_rdata", mem_rdata, 32'hDEADBEEF);
    chk("um_is_wr", 32'(err_is_wr), 0);
    chk("um_rbusy_off", 32'(mem_rbusy), 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_bus_err", 32'(bus_err), 0);
    // timeout read on slave 0, with a stray rvalid and an ignored request
    mem_addr = 32'h00000100; mem_rstrb = 1;
    tick();
    mem_rstrb = 0;
    chk("to_s_ren", 32'(s_ren), 32'b0001);
    s_rvalid = 4'b0010;
    tick();
    s_rvalid = 0;
    chk("to_stray_rbusy", 32'(mem_rbusy), 1);
    chk("to_stray_rdata", mem_rdata, 32'hDEADBEEF);
    mem_addr = 32'h10000000; mem_wmask = 4'hF;
    tick();
    mem_wmask = 0;
    chk("busy_req_no_wen", 32'(s_wen), 0);
    chk("busy_req_no_wbusy", 32'(mem_wbusy), 0);
    tick(); tick(); tick();
    chk("to_err_rbusy", 32'(mem_rbusy), 1);
    chk("to_err_pending", 32'(bus_err), 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("to_rbusy_off", 32'(mem_rbusy), 0);
    chk("to_bus_err_set_wins", 32'(bus_err), 1);
    chk("to_rdata", mem_rdata, 32'hDEADBEEF);
    chk("to_err_addr", err_addr, 32'h100);
    err_clr = 1;
    tick();
    err_clr = 0;
    // rvalid exactly on the timeout cycle completes normally
    mem_addr = 32'h00000020; mem_rstrb = 1; s_rdata[31:0] = 32'hCAFEF00D;
    tick();
    mem_rstrb = 0;
    tick(); tick(); tick(); tick();
    s_rvalid = 4'b0001;
    tick();
    s_rvalid = 0;
    chk("edge_rdata", mem_rdata, 32'hCAFEF00D);
    chk("edge_rbusy", 32'(mem_rbusy), 0);
    chk("edge_no_err", 32'(bus_err), 0);
    // write and read together: the write wins
    mem_addr = 32'h20000000; mem_wmask = 4'hF; mem_rstrb = 1;
    tick();
    mem_wmask = 0; mem_rstrb = 0;
    chk("both_s_wen", 32'(s_wen), 32'b0100);
    chk("both_s_ren", 32'(s_ren), 0);
    s_wready = 4'b0100;
    tick();
    s_wready = 0;
    chk("both_wbusy_off", 32'(mem_wbusy), 0);
    // unmapped write
    mem_addr = 32'h40000008; mem_wmask = 4'b0011;
    tick();
    mem_wmask = 0;
    chk("umw_no_wen", 32'(s_wen), 0);
    chk("umw_wbusy_err", 32'(mem_wbusy), 1);
    tick();
    chk("umw_is_wr", 32'(err_is_wr), 1);
    chk("umw_err_addr", err_addr, 32'h40000008);
    chk("umw_rdata_held", mem_rdata, 32'hCAFEF00D);
    // reset during RD_WAIT, then a late rvalid
    mem_addr = 32'h30000000; mem_rstrb = 1; s_rdata[127:96] = 32'h0BADF00D;
    tick();
    mem_rstrb = 0;
    chk("rr_s_ren", 32'(s_ren), 32'b1000);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rr_rbusy", 32'(mem_rbusy), 0);
    chk("rr_bus_err", 32'(bus_err), 0);
    s_rvalid = 4'b1000;
    tick();
    s_rvalid = 0;
    chk("rr_rdata", mem_rdata, 0);
    chk("rr_no_ren", 32'(s_ren), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
Parametrised single-master, N-slave interconnect between the FemtoRV32 memory port and SoC peripherals (RAM, GPIO, UART, I2C, ...). It generalises the fixed three-way decode/mux to N_SLAVES with a parameter-driven address map. It adds registered slave strobes, wait-state handling through slave rvalid/wready, a per-access timeout, and a sticky bus-error report for unmapped or unresponsive accesses.

Parameters:
N_SLAVES, 4, number of slave ports (1..8)
SLV_BASE, {32'h30000000,32'h20000000,32'h10000000,32'h00000000}, flattened N_SLAVES*32 base addresses; slice i = slave i
SLV_MASK, {4{32'hF0000000}}, flattened N_SLAVES*32 decode masks; slave i hits when (mem_addr & mask_i) == base_i
TIMEOUT_CYCLES, 255, max wait cycles for rvalid/wready; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, read data returned on an error

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
mem_addr  in  32  master address
mem_wdata  in  32  master write data
mem_wmask  in  4  byte write strobes; non-zero starts a write
mem_rstrb  in  1  read strobe, one-cycle pulse
mem_rdata  out  32  read data to master
mem_rbusy  out  1  read in progress
mem_wbusy  out  1  write in progress
s_addr  out  32  registered offset: mem_addr & ~mask of the selected slave
s_wdata  out  32  registered write data
s_wstrb  out  4  registered byte strobes
s_ren  out  N_SLAVES  one-hot read pulse
s_wen  out  N_SLAVES  one-hot write pulse
s_rdata  in  N_SLAVES*32  slave read data, flattened
s_rvalid  in  N_SLAVES  slave read data valid
s_wready  in  N_SLAVES  slave write accepted
err_clr  in  1  pulse: clears bus_err
bus_err  out  1  sticky error flag
err_addr  out  32  address of the most recent error
err_is_wr  out  1  1 if the most recent error was a write

Behaviour:
- Reset (reset_n=0 at a clk edge) forces state IDLE and clears all outputs: mem_rdata=0, rbusy/wbusy=0, s_* =0, bus_err=0, err_addr=0, err_is_wr=0. Reset mid-access aborts the access. No slave strobe is issued after reset.
- Decode is combinational on mem_addr. Lowest slave index wins on overlap. No hit means unmapped.
- FSM states: IDLE, RD_WAIT, WR_WAIT, ERR_RESP.
- IDLE, cycle T, mem_wmask!=0: latch addr/data/strb/slave index. If mapped: s_wen[idx]=1 for cycle T+1 only, wbusy=1 from T+1, go WR_WAIT. If unmapped: go ERR_RESP.
- IDLE, cycle T, mem_rstrb=1 with wmask=0: if mapped, s_ren[idx]=1 for cycle T+1 only, rbusy=1 from T+1, go RD_WAIT. If unmapped, go ERR_RESP.
- If mem_rstrb and mem_wmask are both active in T, the write wins and the read is dropped.
- RD_WAIT: s_rvalid[idx] is sampled starting at T+1. On the valid cycle, s_rdata slice idx is registered into mem_rdata, state goes to IDLE, and rbusy=0 next cycle. Minimum read latency: data valid and rbusy low at T+2. rvalid from a non-selected slave is ignored.
- WR_WAIT: on s_wready[idx], state goes to IDLE and wbusy=0 next cycle.
- Wait counter: 8+ bit counter, cleared on entry to a WAIT state and incremented each WAIT cycle. When count == TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0, the fabric goes to ERR_RESP.
- ERR_RESP: lasts 1 cycle with busy held high. It sets bus_err=1, err_addr=latched address and err_is_wr accordingly. For a read, mem_rdata=ERR_DATA. For a write, nothing is written. Then state goes to IDLE and busy drops.
- A response (rvalid/wready) arriving in the same cycle as the timeout is accepted as a normal completion.
- err_clr in the same cycle as an error set: the set wins.
- Master requests received outside IDLE are ignored, with no strobe and no state change.
- mem_rdata holds its last value until the next read completes.

Test Plan:
- Read slave 2 at 0x20000010, rvalid at T+1 with data 0x12345678 -> s_ren=0b0100 at T+1, s_addr=0x00000010; at T+2 mem_rdata=0x12345678, rbusy=0.
- Write 0x000000AA, wmask=4'b0001 to 0x10000004, wready 3 cycles late -> s_wen=0b0010 one cycle, s_wstrb=0001, wbusy high until the cycle after wready.
- Read 0x50000000 (unmapped) -> no s_ren; bus_err=1, err_addr=0x50000000, mem_rdata=0xDEADBEEF, err_is_wr=0.
- Read slave 0 with TIMEOUT_CYCLES=4 and rvalid never asserted -> rbusy released after the timeout plus ERR_RESP, mem_rdata=0xDEADBEEF, bus_err=1. With rvalid arriving exactly on the timeout cycle -> normal data and no error.
- err_clr pulsed with no error pending -> bus_err=0. err_clr coincident with a new error -> bus_err remains 1.
- reset_n low during RD_WAIT -> next cycle rbusy=0, bus_err=0, and a late rvalid causes no data update.
